// File: rtl/matmul_controller.sv
// matmul_controller: sequences C = A x B over the 3x3 8-bit matrix store.
// Drives every Memory access during a run, accumulates each dot product in an
// 18-bit accumulator, saturates results to 8 bits and pulses done at the end.
// All outputs are registered; they are computed from the next state so the
// registered value lines up with the cycle the FSM spends in that state.
module matmul_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] src_a,
    input  logic [1:0] src_b,
    input  logic [1:0] dst,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       ovf,
    output logic [1:0] mem_matrix_select,
    output logic [1:0] mem_row,
    output logic [1:0] mem_col,
    output logic       mem_read_enable,
    output logic       mem_write_enable,
    output logic [7:0] mem_write_data,
    input  logic [7:0] mem_read_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHK,
        S_RDA,
        S_RDB,
        S_ACC,
        S_WR,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  src_a_q, src_a_d;
    logic [1:0]  src_b_q, src_b_d;
    logic [1:0]  dst_q, dst_d;
    logic [1:0]  i_q, i_d;
    logic [1:0]  j_q, j_d;
    logic [1:0]  k_q, k_d;
    logic [17:0] acc_q, acc_d;
    logic [7:0]  a_q, a_d;
    logic        err_q, err_d;
    logic        ovf_q, ovf_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [1:0]  sel_q, sel_d;
    logic [1:0]  row_q, row_d;
    logic [1:0]  col_q, col_d;
    logic        re_q, re_d;
    logic        we_q, we_d;
    logic [7:0]  wd_q, wd_d;

    logic [15:0] prod;
    logic [17:0] acc_sum;
    logic [7:0]  sat_val;

    // Multiply-accumulate path and 8-bit saturation of the running sum.
    always_comb begin
        prod    = a_q * mem_read_data;
        acc_sum = acc_q + {2'b00, prod};
        sat_val = (acc_sum > 18'd255) ? 8'hFF : acc_sum[7:0];
    end

    // Next-state, counter/datapath updates and registered-output targets.
    always_comb begin
        state_d = state_q;
        src_a_d = src_a_q;
        src_b_d = src_b_q;
        dst_d   = dst_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        acc_d   = acc_q;
        a_d     = a_q;
        err_d   = err_q;
        ovf_d   = ovf_q;
        sel_d   = '0;
        row_d   = '0;
        col_d   = '0;
        re_d    = 1'b0;
        we_d    = 1'b0;
        wd_d    = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    src_a_d = src_a;
                    src_b_d = src_b;
                    dst_d   = dst;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                    acc_d   = '0;
                    err_d   = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = S_CHK;
                end
            end
            S_CHK: begin
                if ((dst_q == src_a_q) || (dst_q == src_b_q)) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_RDA;
                end
            end
            S_RDA: state_d = S_RDB;
            S_RDB: begin
                a_d     = mem_read_data;
                state_d = S_ACC;
            end
            S_ACC: begin
                acc_d = acc_sum;
                if (k_q < 2'd2) begin
                    k_d     = k_q + 2'd1;
                    state_d = S_RDA;
                end else begin
                    // Saturation and ovf are resolved on entry to WR so the
                    // registered write data is ready during the WR cycle.
                    wd_d    = sat_val;
                    if (acc_sum > 18'd255) ovf_d = 1'b1;
                    state_d = S_WR;
                end
            end
            S_WR: begin
                acc_d = '0;
                k_d   = '0;
                if (j_q == 2'd2) begin
                    j_d = '0;
                    if (i_q == 2'd2) begin
                        state_d = S_DONE;
                    end else begin
                        i_d     = i_q + 2'd1;
                        state_d = S_RDA;
                    end
                end else begin
                    j_d     = j_q + 2'd1;
                    state_d = S_RDA;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        case (state_d)
            S_RDA: begin
                re_d  = 1'b1;
                sel_d = src_a_q;
                row_d = i_d;
                col_d = k_d;
            end
            S_RDB: begin
                re_d  = 1'b1;
                sel_d = src_b_q;
                row_d = k_d;
                col_d = j_d;
            end
            S_WR: begin
                we_d  = 1'b1;
                sel_d = dst_q;
                row_d = i_d;
                col_d = j_d;
            end
            default: begin
                wd_d = '0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            src_a_q <= '0;
            src_b_q <= '0;
            dst_q   <= '0;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            acc_q   <= '0;
            a_q     <= '0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sel_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            re_q    <= 1'b0;
            we_q    <= 1'b0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            src_a_q <= src_a_d;
            src_b_q <= src_b_d;
            dst_q   <= dst_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sel_q   <= sel_d;
            row_q   <= row_d;
            col_q   <= col_d;
            re_q    <= re_d;
            we_q    <= we_d;
            wd_q    <= wd_d;
        end
    end

    assign busy              = busy_q;
    assign done              = done_q;
    assign err               = err_q;
    assign ovf               = ovf_q;
    assign mem_matrix_select = sel_q;
    assign mem_row           = row_q;
    assign mem_col           = col_q;
    assign mem_read_enable   = re_q;
    assign mem_write_enable  = we_q;
    assign mem_write_data    = wd_q;

endmodule

// File: tb/tb_matmul_controller.sv
// Bench for matmul_controller: a behavioural 4x3x3 matrix store answers the
// controller's reads with one cycle latency; expected writes and done pulses
// are queued by the driver and checked by an independent monitor.
module tb_matmul_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [1:0] src_a = '0;
    logic [1:0] src_b = '0;
    logic [1:0] dst = '0;
    logic       busy, done, err, ovf;
    logic [1:0] mem_matrix_select, mem_row, mem_col;
    logic       mem_read_enable, mem_write_enable;
    logic [7:0] mem_write_data;
    logic [7:0] mem_read_data = '0;

    matmul_controller dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .src_a             (src_a),
        .src_b             (src_b),
        .dst               (dst),
        .busy              (busy),
        .done              (done),
        .err               (err),
        .ovf               (ovf),
        .mem_matrix_select (mem_matrix_select),
        .mem_row           (mem_row),
        .mem_col           (mem_col),
        .mem_read_enable   (mem_read_enable),
        .mem_write_enable  (mem_write_enable),
        .mem_write_data    (mem_write_data),
        .mem_read_data     (mem_read_data)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Matrix store model with a bench-side load port.
    logic [7:0] mem [4][3][3];
    logic       ld_en = 1'b0;
    logic [1:0] ld_sel = '0;
    logic [1:0] ld_r = '0;
    logic [1:0] ld_c = '0;
    logic [7:0] ld_d = '0;

    always @(posedge clk) begin
        if (ld_en) mem[ld_sel][ld_r][ld_c] <= ld_d;
        if (mem_write_enable) mem[mem_matrix_select][mem_row][mem_col] <= mem_write_data;
        if (mem_read_enable) mem_read_data <= mem[mem_matrix_select][mem_row][mem_col];
    end

    typedef struct {
        int unsigned at;
        logic [1:0]  sel;
        logic [1:0]  row;
        logic [1:0]  col;
        logic [7:0]  data;
    } wr_t;

    typedef struct {
        int unsigned at;
        logic        err;
        logic        ovf;
    } dn_t;

    wr_t wq[$];
    dn_t dq[$];
    int total = 0;
    int bad = 0;

    // Monitor: every write and done pulse must match the head of its queue.
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_write_enable) begin
                total++;
                if (wq.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_write cyc=%0d sel=%0d row=%0d col=%0d data=%0d",
                             cyc, mem_matrix_select, mem_row, mem_col, mem_write_data);
                end else begin
                    wr_t w;
                    w = wq.pop_front();
                    if (cyc != w.at || mem_matrix_select != w.sel || mem_row != w.row ||
                        mem_col != w.col || mem_write_data != w.data) begin
                        bad++;
                        $display("FAIL write got cyc=%0d sel=%0d r=%0d c=%0d d=%0d exp cyc=%0d sel=%0d r=%0d c=%0d d=%0d",
                                 cyc, mem_matrix_select, mem_row, mem_col, mem_write_data,
                                 w.at, w.sel, w.row, w.col, w.data);
                    end
                end
            end
            if (done) begin
                total++;
                if (dq.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_done cyc=%0d", cyc);
                end else begin
                    dn_t d;
                    d = dq.pop_front();
                    if (cyc != d.at || err != d.err || ovf != d.ovf || busy != 1'b1) begin
                        bad++;
                        $display("FAIL done got cyc=%0d err=%0d ovf=%0d busy=%0d exp cyc=%0d err=%0d ovf=%0d busy=1",
                                 cyc, err, ovf, busy, d.at, d.err, d.ovf);
                    end
                end
            end
            if (mem_read_enable && mem_write_enable) begin
                total++;
                bad++;
                $display("FAIL both_enables cyc=%0d", cyc);
            end
        end
    end

    task automatic load_mat(input logic [1:0] sel, input logic [7:0] v [9]);
        for (int unsigned n = 0; n < 9; n++) begin
            @(negedge clk);
            ld_en  = 1'b1;
            ld_sel = sel;
            ld_r   = 2'(n / 3);
            ld_c   = 2'(n % 3);
            ld_d   = v[n];
        end
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic check_mat(input string name, input logic [1:0] sel, input logic [7:0] v [9]);
        int unsigned first;
        bit ok;
        ok = 1'b1;
        first = 0;
        for (int unsigned n = 0; n < 9; n++) begin
            if (ok && mem[sel][n / 3][n % 3] != v[n]) begin
                ok = 1'b0;
                first = n;
            end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s elem=%0d got=%0d exp=%0d", name, first,
                     mem[sel][first / 3][first % 3], v[first]);
        end
    endtask

    task automatic run_start(input logic [1:0] a, input logic [1:0] b, input logic [1:0] d,
                             input bit hold, output int unsigned t0);
        @(negedge clk);
        src_a = a;
        src_b = b;
        dst   = d;
        start = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc;
        if (!hold) start = 1'b0;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL busy_after_start got=%0d exp=1", busy);
        end
    endtask

    task automatic expect_run(input int unsigned t0, input logic [1:0] d,
                              input logic [7:0] c [9], input logic o);
        for (int unsigned n = 0; n < 9; n++) begin
            wr_t w;
            w.at   = t0 + 10 + 10 * n;
            w.sel  = d;
            w.row  = 2'(n / 3);
            w.col  = 2'(n % 3);
            w.data = c[n];
            wq.push_back(w);
        end
        begin
            dn_t e;
            e.at  = t0 + 91;
            e.err = 1'b0;
            e.ovf = o;
            dq.push_back(e);
        end
    endtask

    task automatic drain();
        int unsigned n;
        n = 0;
        while ((wq.size() != 0 || dq.size() != 0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (wq.size() != 0 || dq.size() != 0) begin
            total++;
            bad++;
            $display("FAIL timeout pending_writes=%0d pending_done=%0d", wq.size(), dq.size());
            wq.delete();
            dq.delete();
        end
        repeat (3) @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL busy_idle got=%0d exp=0", busy);
        end
    endtask

    logic [7:0] ident [9];
    logic [7:0] seq9 [9];
    logic [7:0] all200 [9];
    logic [7:0] all255 [9];
    logic [7:0] zeros [9];
    logic [7:0] squares [9];
    int unsigned t0;

    initial begin
        ident   = '{8'd1, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd1};
        seq9    = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
        squares = '{8'd30, 8'd36, 8'd42, 8'd66, 8'd81, 8'd96, 8'd102, 8'd126, 8'd150};
        for (int n = 0; n < 9; n++) begin
            all200[n] = 8'd200;
            all255[n] = 8'd255;
            zeros[n]  = 8'd0;
        end

        repeat (3) @(negedge clk);
        total++;
        if ({busy, done, err, ovf, mem_matrix_select, mem_row, mem_col,
             mem_read_enable, mem_write_enable, mem_write_data} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got=%0h exp=0", {busy, done, err, ovf, mem_matrix_select,
                     mem_row, mem_col, mem_read_enable, mem_write_enable, mem_write_data});
        end
        reset = 1'b0;

        // Identity times 1..9.
        load_mat(2'd0, ident);
        load_mat(2'd1, seq9);
        run_start(2'd0, 2'd1, 2'd2, 1'b0, t0);
        expect_run(t0, 2'd2, seq9, 1'b0);
        drain();
        check_mat("identity_result", 2'd2, seq9);

        // Saturation on every element.
        load_mat(2'd0, all200);
        load_mat(2'd3, all200);
        run_start(2'd0, 2'd3, 2'd2, 1'b0, t0);
        expect_run(t0, 2'd2, all255, 1'b1);
        drain();
        check_mat("saturated_result", 2'd2, all255);

        // Destination aliases a source: rejected, no writes, ovf cleared.
        run_start(2'd0, 2'd1, 2'd0, 1'b0, t0);
        begin
            dn_t e;
            e.at  = t0 + 1;
            e.err = 1'b1;
            e.ovf = 1'b0;
            dq.push_back(e);
        end
        drain();
        check_mat("rejected_src_intact", 2'd0, all200);

        // A squared with a stray start pulse while busy.
        run_start(2'd1, 2'd1, 2'd3, 1'b0, t0);
        expect_run(t0, 2'd3, squares, 1'b0);
        while (cyc != t0 + 9) @(negedge clk);
        src_a = 2'd0;
        src_b = 2'd0;
        dst   = 2'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();
        check_mat("squares_result", 2'd3, squares);

        // Start held through DONE launches a back-to-back run.
        load_mat(2'd0, ident);
        run_start(2'd0, 2'd1, 2'd2, 1'b1, t0);
        expect_run(t0, 2'd2, seq9, 1'b0);
        expect_run(t0 + 93, 2'd2, seq9, 1'b0);
        while (cyc < t0 + 95) @(negedge clk);
        start = 1'b0;
        drain();

        // Reset mid-run: only the first two writes land.
        load_mat(2'd3, zeros);
        run_start(2'd1, 2'd1, 2'd3, 1'b0, t0);
        begin
            wr_t w;
            w.at = t0 + 10; w.sel = 2'd3; w.row = 2'd0; w.col = 2'd0; w.data = 8'd30;
            wq.push_back(w);
            w.at = t0 + 20; w.sel = 2'd3; w.row = 2'd0; w.col = 2'd1; w.data = 8'd36;
            wq.push_back(w);
        end
        while (cyc != t0 + 29) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if ({busy, done, err, ovf, mem_matrix_select, mem_row, mem_col,
             mem_read_enable, mem_write_enable, mem_write_data} !== '0) begin
            bad++;
            $display("FAIL midrun_reset_outputs got=%0h exp=0", {busy, done, err, ovf,
                     mem_matrix_select, mem_row, mem_col, mem_read_enable, mem_write_enable,
                     mem_write_data});
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        drain();
        total++;
        if (mem[3][0][1] != 8'd36 || mem[3][0][2] != 8'd0) begin
            bad++;
            $display("FAIL reset_partial_c got c01=%0d c02=%0d exp c01=36 c02=0",
                     mem[3][0][1], mem[3][0][2]);
        end

        // Normal run after the reset.
        run_start(2'd1, 2'd1, 2'd2, 1'b0, t0);
        expect_run(t0, 2'd2, squares, 1'b0);
        drain();
        check_mat("post_reset_result", 2'd2, squares);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
